ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_sync.sv | 28 ++
 rtl/ps2_host_tx.sv | 161 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: command bytes, host-transmit FSM states, parity helper.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQ     = 3'd2,
    SEND    = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5,
    ERR     = 3'd6
  } ps2_state_t;

  // Odd parity: the bit that makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line with a registered falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic synced,
  output logic fall
);

  logic meta;
  logic prev;

  // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b1;
      synced <= 1'b1;
      prev   <= 1'b1;
      fall   <= 1'b0;
    end else begin
      meta   <= line;
      synced <= meta;
      prev   <= synced;
      fall   <= prev & ~synced;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame on device clock,
// device ACK check, done/error reporting.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = 12_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  // Never hold the clock low for less than the 100 us protocol minimum.
  localparam int unsigned MIN_HOLD     = CLK_FREQ_HZ / 10_000;
  localparam int unsigned INHIBIT_HOLD = (INHIBIT_CYCLES > MIN_HOLD) ? INHIBIT_CYCLES : MIN_HOLD;
  localparam int unsigned CNT_MAX      = (INHIBIT_HOLD > TIMEOUT_CYCLES) ? INHIBIT_HOLD : TIMEOUT_CYCLES;
  localparam int unsigned CW           = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_HOLD - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state;
  logic [7:0]    shreg;
  logic          parity;
  logic [3:0]    bitcnt;
  logic [CW-1:0] cnt;
  logic          clk_oe;
  logic          data_oe;
  logic          clk_s;
  logic          clk_fall;
  logic          data_meta;
  logic          data_s;
  logic          timed_out;

  assign PS2_CLK  = clk_oe  ? 1'b0 : 1'bz;
  assign PS2_DATA = data_oe ? 1'b0 : 1'bz;

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line   (PS2_CLK),
    .synced (clk_s),
    .fall   (clk_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      data_meta <= PS2_DATA;
      data_s    <= data_meta;
    end
  end

  assign timed_out = (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      parity  <= 1'b0;
      bitcnt  <= '0;
      cnt     <= '0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          if (tx_valid) begin
            shreg  <= tx_data;
            parity <= odd_parity(tx_data);
            bitcnt <= '0;
            cnt    <= '0;
            clk_oe <= 1'b1;
            state  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            data_oe <= 1'b1;
            state   <= REQ;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REQ: begin
          clk_oe <= 1'b0;
          cnt    <= '0;
          state  <= SEND;
        end
        SEND: begin
          // Start bit is already on the line; each device fall shifts the next bit out.
          if (clk_fall) begin
            cnt    <= '0;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt < 4'd8) begin
              data_oe <= ~shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end else if (bitcnt == 4'd8) begin
              data_oe <= ~parity;
            end else begin
              data_oe <= 1'b0;
              state   <= ACK;
            end
          end else if (timed_out) begin
            data_oe <= 1'b0;
            state   <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACK: begin
          if (clk_fall) begin
            cnt   <= '0;
            state <= data_s ? ERR : RELEASE;
          end else if (timed_out) begin
            state <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (clk_s && data_s) begin
            state <= IDLE;
          end else if (timed_out) begin
            state <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ERR: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign tx_done  = (state == RELEASE) && clk_s && data_s;
  assign tx_error = (state == ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on pulled-up lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned FREQ = 400_000;
  localparam int unsigned INH  = 40;
  localparam int unsigned TO   = 600;
  localparam int unsigned HALF = 16;  // 12.5 kHz device clock at 400 kHz

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  wire        ps2_clk, ps2_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int last_pulse_cyc = 0;
  bit exp_q[$];
  bit m_busy = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .CLK_FREQ_HZ    (FREQ),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_error (tx_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  // Transaction-level model: one outcome per accepted request, ready/busy follow it.
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      exp_q.delete();
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_pulses", {tx_done, tx_error}, 0);
    end else begin
      chk("ready", tx_ready, !m_busy);
      chk("busy", tx_busy, m_busy);
      if (!m_busy) begin
        if (!dev_clk_low)  chk("idle_clk_released", ps2_clk, 1);
        if (!dev_data_low) chk("idle_data_released", ps2_data, 1);
      end
      if (tx_done || tx_error) begin
        pulses++;
        last_pulse_cyc = cyc;
        chk("pulse_exclusive", tx_done && tx_error, 0);
        chk("pulse_while_busy", m_busy, 1);
        chk("pulse_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("outcome_done", tx_done, exp_q.pop_front());
        m_busy = 1'b0;
      end else if (!m_busy && tx_valid) begin
        m_busy = 1'b1;
      end
    end
  end

  task automatic issue(input logic [7:0] d, input bit expect_done, output int n);
    exp_q.push_back(expect_done);
    tx_data  = d;
    tx_valid = 1'b1;
    n = cyc;
    step();
    tx_valid = 1'b0;
    chk("accept_ready_low", tx_ready, 0);
    chk("accept_clk_low", ps2_clk, 0);
  endtask

  task automatic dev_wait_request(output int td, output int tr);
    int t0;
    t0 = cyc;
    while (ps2_data !== 1'b0 && cyc - t0 < 4 * INH) step();
    chk("start_bit_driven", ps2_data, 0);
    chk("clk_held_at_start", ps2_clk, 0);
    td = cyc;
    while (ps2_clk !== 1'b1 && cyc - t0 < 4 * INH) step();
    chk("clk_released", ps2_clk, 1);
    chk("start_bit_at_release", ps2_data, 0);
    tr = cyc;
    repeat (4) step();
  endtask

  task automatic dev_cycle(output logic bit_v);
    logic early;
    dev_clk_low = 1'b1;
    repeat (4) step();
    early = ps2_data;
    repeat (HALF - 4) step();
    dev_clk_low = 1'b0;
    step();
    bit_v = ps2_data;
    chk("bit_settled_4cyc", early, bit_v);
    repeat (HALF - 1) step();
  endtask

  task automatic dev_frame(input bit ack, output logic [7:0] b, output logic par, output logic stop);
    logic [10:1] bits;
    logic        v;
    for (int f = 1; f <= 10; f++) begin
      dev_cycle(v);
      bits[f] = v;
    end
    if (ack) dev_data_low = 1'b1;
    repeat (4) step();
    dev_clk_low = 1'b1;
    repeat (HALF) step();
    dev_clk_low = 1'b0;
    repeat (4) step();
    dev_data_low = 1'b0;
    b    = bits[8:1];
    par  = bits[9];
    stop = bits[10];
  endtask

  task automatic wait_pulse(input int base);
    int t0;
    t0 = cyc;
    while (pulses == base && cyc - t0 < int'(TO) + 200) step();
    chk("pulse_arrived", pulses, base + 1);
  endtask

  task automatic run_tx(input logic [7:0] d, input bit ack, input bit inject,
                        output logic [7:0] rb, output logic rpar, output logic rstop);
    int n, td, tr, base;
    base = pulses;
    issue(d, ack, n);
    if (inject) begin
      tx_data  = 8'h12;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      step();
    end
    dev_wait_request(td, tr);
    chk("data_oe_latency", td - n, INH + 1);
    chk("clk_release_latency", tr - n, INH + 2);
    chk("inhibit_hold", (tr - n - 1) >= int'(INH), 1);
    dev_frame(ack, rb, rpar, rstop);
    wait_pulse(base);
    chk("ready_after_pulse", tx_ready, 1);
    chk("post_clk_released", ps2_clk, 1);
    chk("post_data_released", ps2_data, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic       rpar, rstop, v;
    int         n, td, tr, base;

    repeat (3) step();
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_done", tx_done, 0);
    chk("reset_error", tx_error, 0);
    chk("reset_clk_line", ps2_clk, 1);
    chk("reset_data_line", ps2_data, 1);
    rst = 1'b0;
    step();

    run_tx(PS2_CMD_SET_LEDS, 1'b1, 1'b0, rb, rpar, rstop);
    chk("rx_byte_ED", rb, 8'hED);
    chk("parity_ED", rpar, 1);
    chk("parity_ED_model", rpar, odd_par(8'hED));
    chk("stop_ED", rstop, 1);

    run_tx(8'h00, 1'b1, 1'b0, rb, rpar, rstop);
    chk("rx_byte_00", rb, 8'h00);
    chk("parity_00", rpar, 1);
    chk("stop_00", rstop, 1);

    run_tx(8'h01, 1'b1, 1'b0, rb, rpar, rstop);
    chk("rx_byte_01", rb, 8'h01);
    chk("parity_01", rpar, 0);
    chk("parity_01_model", rpar, odd_par(8'h01));
    chk("stop_01", rstop, 1);

    run_tx(8'h3C, 1'b0, 1'b0, rb, rpar, rstop);
    chk("rx_byte_nack", rb, 8'h3C);
    chk("parity_3C", rpar, odd_par(8'h3C));

    base = pulses;
    issue(8'hC3, 1'b0, n);
    dev_wait_request(td, tr);
    wait_pulse(base);
    chk("timeout_latency", last_pulse_cyc - tr, TO);
    chk("timeout_ready", tx_ready, 1);
    chk("timeout_data_released", ps2_data, 1);

    issue(8'hAA, 1'b1, n);
    repeat (5) step();
    chk("inhibit_clk_low", ps2_clk, 0);
    rst = 1'b1;
    #1;
    chk("rst_inhibit_clk_release", ps2_clk, 1);
    chk("rst_inhibit_data_release", ps2_data, 1);
    step();
    rst = 1'b0;
    step();
    chk("rst_inhibit_ready", tx_ready, 1);

    issue(8'h00, 1'b1, n);
    dev_wait_request(td, tr);
    for (int f = 0; f < 4; f++) dev_cycle(v);
    dev_clk_low = 1'b1;
    repeat (8) step();
    chk("bit4_driven", ps2_data, 0);
    rst = 1'b1;
    #1;
    chk("rst_send_data_release", ps2_data, 1);
    dev_clk_low = 1'b0;
    #1;
    chk("rst_send_clk_release", ps2_clk, 1);
    step();
    rst = 1'b0;
    step();
    chk("rst_send_ready", tx_ready, 1);
    repeat (HALF) step();

    run_tx(PS2_CMD_ENABLE, 1'b1, 1'b0, rb, rpar, rstop);
    chk("rx_byte_F4", rb, 8'hF4);
    chk("parity_F4", rpar, 0);
    chk("stop_F4", rstop, 1);

    run_tx(PS2_CMD_RESET, 1'b1, 1'b1, rb, rpar, rstop);
    chk("rx_byte_FF_not_12", rb, 8'hFF);
    chk("parity_FF", rpar, 1);

    repeat (5) step();
    chk("queue_empty", exp_q.size(), 0);
    chk("pulse_total", pulses, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
